// File: rtl/sdram_lfsr_tester_pkg.sv
// Shared definitions for the SDRAM LFSR tester: FSM encodings, LFSR taps and seed.
package sdram_lfsr_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 as a right-shifting Fibonacci register:
    // feedback is the XOR of bits 0, 2, 3 and 5, shifted in at bit 15.
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/sdram_lfsr_tester_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
module lfsr16
    import sdram_lfsr_tester_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [15:0] i_seed,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_seed;
        end else if (i_step) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sdram_lfsr_tester.sv
// SDRAM traffic generator/checker: writes an LFSR pattern, reads it back pipelined and compares.
// Optional macro SDRAM_TESTER_ERR_INJECT_EN adds i_inject to corrupt bit 0 of accepted writes.
//
//   state | meaning
//   IDLE  | waiting for i_start
//   WRITE | writing generator LFSR to 0..LAST_ADDR
//   READ  | issuing reads, at most MAX_PENDING outstanding
//   DRAIN | all reads issued, waiting for outstanding data
//   DONE  | one-cycle end-of-pass pulse
module sdram_lfsr_tester
    import sdram_lfsr_tester_pkg::*;
#(
    parameter int                ADDR_W      = 22,
    parameter int                DATA_W      = 16,
    parameter logic [ADDR_W-1:0] LAST_ADDR   = 22'h3FFFFF,
    parameter logic [15:0]       LFSR_SEED   = DEFAULT_SEED,
    parameter int                MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
`ifdef SDRAM_TESTER_ERR_INJECT_EN
    input  logic              i_inject,
`endif
    output logic              o_rd_n,
    output logic              o_wr_n,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_be_n,
    input  logic              i_wait_req,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [15:0]       o_err_count,
    output logic [15:0]       o_pass_count,
    output logic              o_ram_writing,
    output logic              o_ram_reading,
    output logic [15:0]       o_debug
);

    localparam logic [2:0] MAX_P = 3'(MAX_PENDING);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_pending;
    logic [15:0]       r_chk_idx;
    logic [15:0]       r_err_count;
    logic [15:0]       r_pass_count;
    logic              r_error;
    logic [15:0]       r_debug;

    logic              w_inj;
    logic              w_at_last;
    logic              w_wr_acc;
    logic              w_rd_req;
    logic              w_rd_acc;
    logic              w_in_rd;
    logic              w_valid_ok;
    logic              w_mismatch;
    logic              w_gen_load;
    logic              w_gen_step;
    logic              w_chk_load;
    logic [15:0]       w_gen_q;
    logic [15:0]       w_chk_q;

`ifdef SDRAM_TESTER_ERR_INJECT_EN
    assign w_inj = i_inject;
`else
    assign w_inj = 1'b0;
`endif

    assign w_at_last  = (r_addr == LAST_ADDR);
    assign w_wr_acc   = (r_state == ST_WRITE) && !i_wait_req;
    assign w_rd_req   = (r_state == ST_READ) && (r_pending < MAX_P);
    assign w_rd_acc   = w_rd_req && !i_wait_req;
    assign w_in_rd    = (r_state == ST_READ) || (r_state == ST_DRAIN);
    // Data with nothing outstanding (or outside a read phase) is itself an error and is not checked.
    assign w_valid_ok = i_valid && w_in_rd && (r_pending != 3'd0);
    assign w_mismatch = (i_valid && !w_valid_ok) || (w_valid_ok && (i_data != w_chk_q));

    assign w_gen_load = ((r_state == ST_IDLE) && i_start) || (w_wr_acc && w_at_last);
    assign w_gen_step = w_wr_acc && !w_at_last;
    assign w_chk_load = (r_state == ST_DONE);

    lfsr16 #(.RESET_VAL(LFSR_SEED)) u_gen (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_gen_load),
        .i_step (w_gen_step),
        .i_seed (LFSR_SEED),
        .o_q    (w_gen_q)
    );

    lfsr16 #(.RESET_VAL(LFSR_SEED)) u_chk (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_chk_load),
        .i_step (w_valid_ok),
        .i_seed (LFSR_SEED),
        .o_q    (w_chk_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next_state = ST_WRITE;
            ST_WRITE: if (w_wr_acc && w_at_last) w_next_state = ST_READ;
            ST_READ:  if (w_rd_acc && w_at_last) w_next_state = ST_DRAIN;
            ST_DRAIN: if (r_pending == 3'd0) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Read address stops at LAST_ADDR in DRAIN; the next pass restarts it from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_addr <= '0;
        end else if (w_wr_acc) begin
            r_addr <= w_at_last ? '0 : r_addr + 1'b1;
        end else if (w_rd_acc && !w_at_last) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 3'd0;
        end else begin
            case ({w_rd_acc, w_valid_ok})
                2'b10:   r_pending <= r_pending + 3'd1;
                2'b01:   r_pending <= r_pending - 3'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chk_idx    <= 16'd0;
            r_pass_count <= 16'd0;
        end else if (r_state == ST_DONE) begin
            r_chk_idx    <= 16'd0;
            r_pass_count <= r_pass_count + 16'd1;
        end else if (w_valid_ok) begin
            r_chk_idx    <= r_chk_idx + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= 16'd0;
            r_error     <= 1'b0;
            r_debug     <= 16'd0;
        end else if (w_mismatch) begin
            if (r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
            r_error <= 1'b1;
            if (!r_error) begin
                r_debug <= r_chk_idx;
            end
        end
    end

    assign o_wr_n        = (r_state != ST_WRITE);
    assign o_rd_n        = !w_rd_req;
    assign o_addr        = r_addr;
    assign o_data        = (r_state == ST_WRITE) ? (w_gen_q ^ {15'd0, w_inj}) : '0;
    assign o_be_n        = 2'b00;
    assign o_busy        = (r_state == ST_WRITE) || w_in_rd;
    assign o_done        = (r_state == ST_DONE);
    assign o_error       = r_error;
    assign o_err_count   = r_err_count;
    assign o_pass_count  = r_pass_count;
    assign o_ram_writing = (r_state == ST_WRITE);
    assign o_ram_reading = w_in_rd;
    assign o_debug       = r_debug;

endmodule

// File: tb/tb_sdram_lfsr_tester.sv
// Bench for sdram_lfsr_tester: SDRAM controller model with configurable stall/latency and write scoreboard.
`timescale 1ns/1ps
module tb_sdram_lfsr_tester;

    localparam int          MAXP = 4;
    localparam int          NWORDS = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_wait_req = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = 16'd0;
`ifdef SDRAM_TESTER_ERR_INJECT_EN
    logic        i_inject = 1'b0;
`endif
    logic        o_rd_n, o_wr_n, o_busy, o_done, o_error, o_ram_writing, o_ram_reading;
    logic [21:0] o_addr;
    logic [15:0] o_data, o_err_count, o_pass_count, o_debug;
    logic [1:0]  o_be_n;

    always #5 clk = ~clk;

    sdram_lfsr_tester #(
        .ADDR_W(22), .DATA_W(16), .LAST_ADDR(22'd15), .LFSR_SEED(SEED), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
`ifdef SDRAM_TESTER_ERR_INJECT_EN
        .i_inject(i_inject),
`endif
        .o_rd_n(o_rd_n), .o_wr_n(o_wr_n), .o_addr(o_addr), .o_data(o_data), .o_be_n(o_be_n),
        .i_wait_req(i_wait_req), .i_valid(i_valid), .i_data(i_data),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_count(o_err_count),
        .o_pass_count(o_pass_count), .o_ram_writing(o_ram_writing),
        .o_ram_reading(o_ram_reading), .o_debug(o_debug)
    );

    typedef struct { int due; logic [15:0] data; } rd_t;
    typedef struct { logic [21:0] addr; logic [15:0] data; } wr_t;

    rd_t         rq[$];
    wr_t         exp_wr[$];
    logic [15:0] mem [0:15];
    int          total = 0, bad = 0, cyc = 0, lat = 3, corrupt_addr = -1;
    int          done_cnt = 0, wr_cnt = 0, rd_cnt = 0, max_out = 0, exp_pass = 0, inject_idx = 0;
    bit          stall_en = 0, same_seen = 0, inject_en = 0;
    bit          prev_wr_stall = 0, prev_rd_stall = 0;
    logic [21:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    function automatic logic [15:0] model_next(input logic [15:0] q);
        return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    endfunction

    task automatic push_pass();
        logic [15:0] v = SEED;
        for (int a = 0; a < NWORDS; a++) begin
            exp_wr.push_back('{22'(a), v});
            v = model_next(v);
        end
    endtask

    // One controller-model cycle: inputs driven at negedge, outputs sampled 1 ns later.
    task automatic cycle();
        rd_t r;
        wr_t e;
        logic [15:0] d;
        bit inj_now;
        @(negedge clk);
        i_wait_req = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        i_valid = 1'b0;
        i_data = 16'd0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            i_valid = 1'b1;
            i_data = r.data;
        end
        inj_now = inject_en && (wr_cnt == inject_idx);
`ifdef SDRAM_TESTER_ERR_INJECT_EN
        i_inject = inj_now;
`endif
        #1;
        if (prev_wr_stall) begin
            total++;
            if (o_wr_n !== 1'b0 || o_addr !== prev_addr || o_data !== prev_data) begin
                bad++;
                $display("FAIL wr_stall_hold wr_n=%b addr=%h data=%h required addr=%h data=%h",
                         o_wr_n, o_addr, o_data, prev_addr, prev_data);
            end
        end
        if (prev_rd_stall) begin
            total++;
            if (o_rd_n !== 1'b0 || o_addr !== prev_addr) begin
                bad++;
                $display("FAIL rd_stall_hold rd_n=%b addr=%h required addr=%h", o_rd_n, o_addr, prev_addr);
            end
        end
        prev_wr_stall = (o_wr_n === 1'b0) && i_wait_req;
        prev_rd_stall = (o_rd_n === 1'b0) && i_wait_req;
        prev_addr = o_addr;
        prev_data = o_data;
        if (o_wr_n === 1'b0 && !i_wait_req) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_extra addr=%h data=%h required no write", o_addr, o_data);
            end else begin
                e = exp_wr.pop_front();
                d = e.data ^ {15'd0, inj_now};
                if (o_addr !== e.addr || o_data !== d) begin
                    bad++;
                    $display("FAIL wr_word addr=%h data=%h required addr=%h data=%h",
                             o_addr, o_data, e.addr, d);
                end
            end
            mem[o_addr[3:0]] = o_data;
            wr_cnt++;
        end
        if (o_rd_n === 1'b0 && !i_wait_req) begin
            if (i_valid) same_seen = 1;
            d = mem[o_addr[3:0]];
            if (o_addr == corrupt_addr) d = d ^ 16'h0001;
            rq.push_back('{cyc + lat, d});
            rd_cnt++;
        end
        if (rq.size() > max_out) max_out = rq.size();
        if (o_done === 1'b1) done_cnt++;
        cyc++;
    endtask

    // Runs n passes (start pulsed for n=1, held otherwise) and checks the end-of-run status.
    task automatic run_pass(input int n, input string tag);
        int budget = 0;
        done_cnt = 0; wr_cnt = 0; rd_cnt = 0; max_out = 0; same_seen = 0;
        for (int k = 0; k < n; k++) push_pass();
        i_start = 1'b1;
        while (done_cnt < n && budget < 3000) begin
            cycle();
            budget++;
            if (n == 1) i_start = 1'b0;
        end
        i_start = 1'b0;
        total++;
        if (done_cnt != n) begin
            bad++;
            $display("FAIL %s_timeout done=%0d required %0d", tag, done_cnt, n);
        end
        repeat (4) cycle();
        exp_pass += n;
        total++;
        if (done_cnt != n) begin
            bad++;
            $display("FAIL %s_done_pulses got=%0d required %0d", tag, done_cnt, n);
        end
        total++;
        if (exp_wr.size() != 0 || wr_cnt != n * NWORDS || rd_cnt != n * NWORDS) begin
            bad++;
            $display("FAIL %s_word_counts left=%0d wr=%0d rd=%0d required 0/%0d/%0d",
                     tag, exp_wr.size(), wr_cnt, rd_cnt, n * NWORDS, n * NWORDS);
        end
        total++;
        if (o_pass_count !== 16'(exp_pass) || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_pass_count got=%0d busy=%b required %0d busy=0",
                     tag, o_pass_count, o_busy, exp_pass);
        end
    endtask

    task automatic check_err(input string tag, input logic [15:0] cnt, input logic err);
        total++;
        if (o_err_count !== cnt || o_error !== err) begin
            bad++;
            $display("FAIL %s_err got cnt=%0d err=%b required cnt=%0d err=%b", tag, o_err_count, o_error, cnt, err);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (o_rd_n !== 1'b1 || o_wr_n !== 1'b1 || o_addr !== '0 || o_data !== '0 || o_be_n !== 2'b00 ||
            o_done !== 1'b0 || o_busy !== 1'b0 || o_debug !== '0 || o_pass_count !== '0) begin
            bad++;
            $display("FAIL reset_outputs rd=%b wr=%b addr=%h data=%h be=%b done=%b busy=%b dbg=%h pass=%0d required 1 1 0 0 00 0 0 0 0",
                     o_rd_n, o_wr_n, o_addr, o_data, o_be_n, o_done, o_busy, o_debug, o_pass_count);
        end
        check_err("reset", 16'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        lat = 3; stall_en = 0; corrupt_addr = -1;
        run_pass(1, "basic");
        check_err("basic", 16'd0, 1'b0);
    endtask

    task automatic test_stall();
        lat = 3; stall_en = 1;
        run_pass(1, "stall");
        stall_en = 0;
        check_err("stall", 16'd0, 1'b0);
    endtask

    task automatic test_pending();
        lat = 10;
        run_pass(1, "pending");
        total++;
        if (max_out != MAXP) begin
            bad++;
            $display("FAIL pending_max got=%0d required %0d", max_out, MAXP);
        end
        total++;
        if (!same_seen) begin
            bad++;
            $display("FAIL pending_same_cycle got=0 required 1");
        end
        check_err("pending", 16'd0, 1'b0);
        lat = 3;
    endtask

    task automatic test_back_to_back();
        run_pass(2, "b2b");
        check_err("b2b", 16'd0, 1'b0);
    endtask

    task automatic test_corrupt();
        corrupt_addr = 5;
        run_pass(1, "corrupt");
        corrupt_addr = -1;
        check_err("corrupt", 16'd1, 1'b1);
        total++;
        if (o_debug !== 16'h0005) begin
            bad++;
            $display("FAIL corrupt_debug got=%h required 0005", o_debug);
        end
        run_pass(1, "sticky");
        check_err("sticky", 16'd1, 1'b1);
    endtask

    task automatic test_reset_mid_read();
        int budget = 0;
        push_pass();
        done_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        i_start = 1'b1;
        cycle();
        i_start = 1'b0;
        while (!(o_ram_reading === 1'b1 && rq.size() >= 2) && budget < 500) begin
            cycle();
            budget++;
        end
        total++;
        if (budget >= 500) begin
            bad++;
            $display("FAIL midread_reach got=timeout required reading with 2 outstanding");
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_wait_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if (o_rd_n !== 1'b1 || o_wr_n !== 1'b1 || o_pass_count !== '0 || o_debug !== '0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL midread_reset rd=%b wr=%b pass=%0d dbg=%h busy=%b required 1 1 0 0 0",
                     o_rd_n, o_wr_n, o_pass_count, o_debug, o_busy);
        end
        check_err("midread_reset", 16'd0, 1'b0);
        rq.delete();
        exp_wr.delete();
        prev_wr_stall = 0;
        prev_rd_stall = 0;
        exp_pass = 0;
        @(negedge clk);
        reset = 1'b0;
        run_pass(1, "after_reset");
        check_err("after_reset", 16'd0, 1'b0);
    endtask

`ifdef SDRAM_TESTER_ERR_INJECT_EN
    task automatic test_inject();
        inject_en = 1;
        inject_idx = 2;
        run_pass(2, "inject");
        inject_en = 0;
        check_err("inject", 16'd1, 1'b1);
        total++;
        if (o_debug !== 16'h0002) begin
            bad++;
            $display("FAIL inject_debug got=%h required 0002", o_debug);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
        test_reset();
        test_basic();
        test_stall();
        test_pending();
        test_back_to_back();
        test_corrupt();
        test_reset_mid_read();
`ifdef SDRAM_TESTER_ERR_INJECT_EN
        test_inject();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
